pixel_frame_streamer: RTL and testbench

Frame-source block at the head of the dehazing pipeline. Reads a stored RGB888 image from a synchronous-read frame memory in raster order and emits it as a one-pixel-per-cycle valid-qualified stream, which feeds the 3x3 window-generation stage. It adds a programmable idle gap between rows and a level-sensitive stall input. Completion is reported with a pulse.

---
 rtl/pixel_frame_streamer.sv | 141 ++++++++++++++
 tb/tb_pixel_frame_streamer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_frame_streamer.sv
// Raster-order frame source: reads RGB888 pixels from a synchronous-read frame memory and
// streams them one per cycle with inter-row gaps and a level stall. Option: BORDER_PAD_EN.
module pixel_frame_streamer #(
  parameter int unsigned ROW_SIZE = 512,
  parameter int unsigned NUM_ROWS = 512,
  parameter int unsigned ADDR_W   = 18,
  parameter int unsigned LINE_GAP = 4
) (
  input  logic              r_clk,
  input  logic              r_rst,
  input  logic              start,
  input  logic              hold,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [23:0]       mem_rdata,
  output logic [23:0]       pixel_data,
  output logic              pixel_valid,
  output logic              busy,
  output logic              frame_done
);

`ifdef BORDER_PAD_EN
  localparam int unsigned TotalRows = NUM_ROWS + 2;
`else
  localparam int unsigned TotalRows = NUM_ROWS;
`endif

  localparam int unsigned ColW       = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
  localparam int unsigned RowW       = (TotalRows > 1) ? $clog2(TotalRows) : 1;
  localparam int unsigned GapW       = (LINE_GAP > 1) ? $clog2(LINE_GAP) : 1;
  localparam int unsigned GapLastInt = (LINE_GAP > 0) ? LINE_GAP - 1 : 0;

  localparam logic [ColW-1:0] ColLast = ColW'(ROW_SIZE - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(TotalRows - 1);
  localparam logic [GapW-1:0] GapLast = GapW'(GapLastInt);

  typedef enum logic [1:0] {StIdle, StIssue, StGap, StDrain} state_e;

  state_e              r_state, w_state_d;
  logic [ColW-1:0]     r_col, w_col_d;
  logic [RowW-1:0]     r_row, w_row_d;
  logic [ADDR_W-1:0]   r_row_base, w_row_base_d;
  logic [GapW-1:0]     r_gap_cnt, w_gap_cnt_d;
  logic                r_rd_pend;
  logic                r_pixel_valid;
  logic [23:0]         r_pixel_data;
  logic                r_frame_done, w_frame_done_d;
  logic                w_issue;
  logic                w_last_row;
  logic                w_advance_base;

  assign w_last_row = (r_row == RowLast);

`ifdef BORDER_PAD_EN
  // Padded rows 0/1 share source row 0 and the last two share NUM_ROWS-1.
  assign w_advance_base = (r_row != '0) && (r_row < RowW'(NUM_ROWS));
`else
  assign w_advance_base = 1'b1;
`endif

  always_comb begin
    w_state_d      = r_state;
    w_col_d        = r_col;
    w_row_d        = r_row;
    w_row_base_d   = r_row_base;
    w_gap_cnt_d    = r_gap_cnt;
    w_issue        = 1'b0;
    w_frame_done_d = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start) w_state_d = StIssue;
      end
      StIssue: begin
        w_issue = !hold;
        if (w_issue) begin
          if (r_col == ColLast) begin
            w_col_d = '0;
            if (w_last_row) begin
              w_state_d = StDrain;
            end else begin
              w_row_d = r_row + RowW'(1);
              if (w_advance_base) w_row_base_d = r_row_base + ADDR_W'(ROW_SIZE);
              if (LINE_GAP != 0) begin
                w_state_d   = StGap;
                w_gap_cnt_d = '0;
              end
            end
          end else begin
            w_col_d = r_col + ColW'(1);
          end
        end
      end
      StGap: begin
        if (r_gap_cnt == GapLast) w_state_d = StIssue;
        else w_gap_cnt_d = r_gap_cnt + GapW'(1);
      end
      StDrain: begin
        // The last read's data is in the output register once no read is pending.
        if (!r_rd_pend) begin
          w_state_d      = StIdle;
          w_frame_done_d = 1'b1;
          w_row_d        = '0;
          w_col_d        = '0;
          w_row_base_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      r_state       <= StIdle;
      r_col         <= '0;
      r_row         <= '0;
      r_row_base    <= '0;
      r_gap_cnt     <= '0;
      r_rd_pend     <= 1'b0;
      r_pixel_valid <= 1'b0;
      r_pixel_data  <= '0;
      r_frame_done  <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_col         <= w_col_d;
      r_row         <= w_row_d;
      r_row_base    <= w_row_base_d;
      r_gap_cnt     <= w_gap_cnt_d;
      r_rd_pend     <= w_issue;
      r_pixel_valid <= r_rd_pend;
      if (r_rd_pend) r_pixel_data <= mem_rdata;
      r_frame_done  <= w_frame_done_d;
    end
  end

  assign mem_rd_en   = w_issue;
  assign mem_addr    = r_row_base + ADDR_W'(r_col);
  assign pixel_data  = r_pixel_data;
  assign pixel_valid = r_pixel_valid;
  assign busy        = (r_state != StIdle);
  assign frame_done  = r_frame_done;

endmodule

// File: tb/tb_pixel_frame_streamer.sv
// Self-checking bench for pixel_frame_streamer: randomized hold against a cycle-schedule model
// built from the row/gap/latency rules; honours BORDER_PAD_EN when defined.
module tb_pixel_frame_streamer;
  localparam int RS = 4;
  localparam int NR = 3;
  localparam int LG = 2;
  localparam int AW = 18;
  localparam int NC = 400;
`ifdef BORDER_PAD_EN
  localparam int RowsOut = NR + 2;
`else
  localparam int RowsOut = NR;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic tb_start = 1'b0;
  logic tb_hold  = 1'b0;
  int   tb_sel   = 0;

  logic          start0, hold0, start1, hold1;
  logic          rd0, rd1;
  logic [AW-1:0] addr0, addr1;
  logic [23:0]   rdata0 = '0;
  logic [23:0]   rdata1 = '0;
  logic [23:0]   pd0, pd1;
  logic          pv0, pv1, busy0, busy1, fd0, fd1;

  assign start0 = (tb_sel == 0) && tb_start;
  assign hold0  = (tb_sel == 0) && tb_hold;
  assign start1 = (tb_sel == 1) && tb_start;
  assign hold1  = (tb_sel == 1) && tb_hold;

  always @(posedge clk) if (rd0) rdata0 <= 24'(addr0);
  always @(posedge clk) if (rd1) rdata1 <= 24'(addr1);

  pixel_frame_streamer #(
    .ROW_SIZE(RS), .NUM_ROWS(NR), .ADDR_W(AW), .LINE_GAP(LG)
  ) u_dut (
    .r_clk(clk), .r_rst(rst), .start(start0), .hold(hold0),
    .mem_rd_en(rd0), .mem_addr(addr0), .mem_rdata(rdata0),
    .pixel_data(pd0), .pixel_valid(pv0), .busy(busy0), .frame_done(fd0)
  );

  pixel_frame_streamer #(
    .ROW_SIZE(RS), .NUM_ROWS(NR), .ADDR_W(AW), .LINE_GAP(0)
  ) u_dut_nogap (
    .r_clk(clk), .r_rst(rst), .start(start1), .hold(hold1),
    .mem_rd_en(rd1), .mem_addr(addr1), .mem_rdata(rdata1),
    .pixel_data(pd1), .pixel_valid(pv1), .busy(busy1), .frame_done(fd1)
  );

  logic          ob_valid, ob_rd, ob_busy, ob_done;
  logic [23:0]   ob_data;
  logic [AW-1:0] ob_addr;
  assign ob_valid = (tb_sel == 0) ? pv0 : pv1;
  assign ob_rd    = (tb_sel == 0) ? rd0 : rd1;
  assign ob_busy  = (tb_sel == 0) ? busy0 : busy1;
  assign ob_done  = (tb_sel == 0) ? fd0 : fd1;
  assign ob_data  = (tb_sel == 0) ? pd0 : pd1;
  assign ob_addr  = (tb_sel == 0) ? addr0 : addr1;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: hold per cycle, expected issues/pixels per cycle.
  bit            hp[NC];
  bit            ei[NC];
  logic [AW-1:0] ea[NC];
  bit            ev[NC];
  logic [23:0]   edat[NC];
  logic [23:0]   exp_pd[2];

  function automatic int row_src(input int k);
`ifdef BORDER_PAD_EN
    if (k == 0) return 0;
    if (k > NR) return NR - 1;
    return k - 1;
`else
    return k;
`endif
  endfunction

  function automatic void clear_model();
    for (int c = 0; c < NC; c++) begin
      ei[c] = 1'b0; ev[c] = 1'b0; ea[c] = '0; edat[c] = '0;
    end
  endfunction

  function automatic void fill_hold(input int mode);
    for (int c = 0; c < NC; c++) begin
      if (mode == 1)      hp[c] = (c >= 2 && c <= 5);
      else if (mode == 2) hp[c] = (c < 120) && ($urandom_range(99) < 30);
      else                hp[c] = 1'b0;
    end
  endfunction

  // Frame accepted at cycle base; returns the frame_done cycle.
  function automatic int model_frame(input int gap, input int base);
    int t = base + 1;
    for (int k = 0; k < RowsOut; k++) begin
      int src = row_src(k);
      for (int col = 0; col < RS; col++) begin
        while (hp[t]) t++;
        ei[t]       = 1'b1;
        ea[t]       = AW'(src * RS + col);
        ev[t + 2]   = 1'b1;
        edat[t + 2] = 24'(src * RS + col);
        t++;
      end
      if (k != RowsOut - 1) t += gap;
    end
    return t - 1 + 3;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      tb_sel = d;
      #0;
      n_checks++;
      if ({ob_valid, ob_rd, ob_busy, ob_done} !== 4'b0000 || ob_data !== '0 || ob_addr !== '0)
        $display("FAIL reset dut%0d: valid/rd/busy/done=%b data=%h addr=%h, want all 0",
                 d, {ob_valid, ob_rd, ob_busy, ob_done}, ob_data, ob_addr);
      else n_pass++;
    end
    tb_sel = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_pd[0] = '0;
    exp_pd[1] = '0;
  endtask

  task automatic test_frames();
    int    s_sel[9]   = '{0, 0, 0, 0, 0, 0, 1, 1, 1};
    int    s_mode[9]  = '{0, 1, 0, 2, 2, 2, 0, 2, 2};
    int    s_extra[9] = '{-1, -1, 10, -1, -1, 7, -1, -1, -1};
    string s_name[9]  = '{"basic", "stall", "start_busy", "rand0", "rand1", "rand2",
                          "nogap", "nogap_rand0", "nogap_rand1"};
    for (int s = 0; s < 9; s++) begin
      int done;
      tb_sel = s_sel[s];
      clear_model();
      fill_hold(s_mode[s]);
      done = model_frame((s_sel[s] == 0) ? LG : 0, 0);
      for (int c = 0; c <= done; c++) begin
        @(posedge clk); #1;
        tb_start = (c == 0) || (c == s_extra[s]);
        tb_hold  = hp[c];
        @(negedge clk);
        if (ev[c]) exp_pd[tb_sel] = edat[c];
        n_checks++;
        if (ob_valid !== ev[c])
          $display("FAIL %s c=%0d pixel_valid got %b want %b", s_name[s], c, ob_valid, ev[c]);
        else n_pass++;
        n_checks++;
        if (ob_data !== exp_pd[tb_sel])
          $display("FAIL %s c=%0d pixel_data got %h want %h", s_name[s], c, ob_data,
                   exp_pd[tb_sel]);
        else n_pass++;
        n_checks++;
        if (ob_rd !== ei[c] || (ei[c] && ob_addr !== ea[c]))
          $display("FAIL %s c=%0d mem_rd_en/addr got %b/%h want %b/%h", s_name[s], c, ob_rd,
                   ob_addr, ei[c], ea[c]);
        else n_pass++;
        n_checks++;
        if (ob_busy !== (c >= 1 && c < done) || ob_done !== (c == done))
          $display("FAIL %s c=%0d busy/frame_done got %b/%b want %b/%b", s_name[s], c, ob_busy,
                   ob_done, (c >= 1 && c < done), (c == done));
        else n_pass++;
      end
      tb_start = 1'b0;
      tb_hold  = 1'b0;
    end
    tb_sel = 0;
  endtask

  task automatic test_back_to_back();
    int d1, d2;
    tb_sel = 0;
    clear_model();
    fill_hold(2);
    d1 = model_frame(LG, 0);
    d2 = model_frame(LG, d1);
    for (int c = 0; c <= d2; c++) begin
      logic exp_busy;
      @(posedge clk); #1;
      tb_start = (c == 0) || (c == d1);
      tb_hold  = hp[c];
      @(negedge clk);
      exp_busy = (c >= 1 && c < d1) || (c > d1 && c < d2);
      if (ev[c]) exp_pd[0] = edat[c];
      n_checks++;
      if (ob_valid !== ev[c] || ob_data !== exp_pd[0])
        $display("FAIL b2b c=%0d valid/data got %b/%h want %b/%h", c, ob_valid, ob_data, ev[c],
                 exp_pd[0]);
      else n_pass++;
      n_checks++;
      if (ob_rd !== ei[c] || (ei[c] && ob_addr !== ea[c]))
        $display("FAIL b2b c=%0d mem_rd_en/addr got %b/%h want %b/%h", c, ob_rd, ob_addr, ei[c],
                 ea[c]);
      else n_pass++;
      n_checks++;
      if (ob_busy !== exp_busy || ob_done !== (c == d1 || c == d2))
        $display("FAIL b2b c=%0d busy/frame_done got %b/%b want %b/%b", c, ob_busy, ob_done,
                 exp_busy, (c == d1 || c == d2));
      else n_pass++;
    end
    tb_start = 1'b0;
    tb_hold  = 1'b0;
  endtask

  task automatic test_reset_mid();
    tb_sel = 0;
    for (int c = 0; c <= 22; c++) begin
      @(posedge clk); #1;
      tb_start = (c == 0);
      tb_hold  = 1'b0;
      rst      = (c >= 8 && c <= 10);
      @(negedge clk);
      if (c >= 9) begin
        n_checks++;
        if ({ob_valid, ob_rd, ob_busy, ob_done} !== 4'b0000 || ob_data !== '0 ||
            ob_addr !== '0)
          $display("FAIL reset_mid c=%0d valid/rd/busy/done=%b data=%h addr=%h, want all 0",
                   c, {ob_valid, ob_rd, ob_busy, ob_done}, ob_data, ob_addr);
        else n_pass++;
      end
    end
    rst       = 1'b0;
    exp_pd[0] = '0;
  endtask

  initial begin
    test_reset();
    test_frames();
    test_back_to_back();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
